// File: rtl/cdc_rx_pkg.sv
// Shared definitions for the req/ack CDC receive block: FSM state encoding and
// the legal range of the request synchroniser depth.
// Optional checker macro used by the channel: CDC_RX_PROTOCOL_CHECK_EN.
package cdc_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } cdc_rx_state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic bit sync_stages_ok(input int unsigned n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/cdc_rx_channel.sv
// One receive channel: request synchroniser, capture register, valid/ready FSM, ack flop.
// Latency: out_valid_o rises SYNC_STAGES+1 edges after req_i changes; ack_o moves on the accept edge.
// Backpressure: while out_ready_i is low the channel holds in HOLD and withholds the ack.
// Ports: clk, reset (async active-low), req_i/data_i from the sender, ack_o back to it,
//        out_valid_o/out_data_o/out_ready_i local handshake, cap_pulse_o capture strobe,
//        proto_err_o sticky protocol flag (only live when CDC_RX_PROTOCOL_CHECK_EN is defined).
module cdc_rx_channel
  import cdc_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FOUR_PHASE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              cap_pulse_o,
  output logic              proto_err_o
);

  // Plain shift chain; req_i feeds the first flop with nothing in between.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];

  cdc_rx_state_e     state_q;
  logic              ack_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              cap_q;
  logic              seen_q;
  logic              req_event;

  // Level protocol: a high request is the event. Toggle protocol: any change
  // relative to the last request level we consumed.
  assign req_event = (FOUR_PHASE != 0) ? req_sync : (req_sync ^ seen_q);

  // ack_q is written on the same edge as the state transition so the sender
  // sees the ack straight from a flop with no decode glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cap_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      cap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_event) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            cap_q   <= 1'b1;
            seen_q  <= req_sync;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            if (FOUR_PHASE != 0) begin
              ack_q   <= 1'b1;
              state_q <= ST_ACK;
            end else begin
              // Toggle ack to mirror the request level just consumed.
              ack_q   <= seen_q;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_ACK: begin
          if (!req_sync) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign cap_pulse_o = cap_q;

`ifdef CDC_RX_PROTOCOL_CHECK_EN
  // HOLD is only entered with req_sync equal to seen_q (level 1 in 4-phase),
  // so any disagreement while still holding is a premature request change.
  logic err_q;
  logic violation;

  assign violation = (state_q == ST_HOLD) &&
                     ((FOUR_PHASE != 0) ? !req_sync : (req_sync != seen_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (violation) begin
      err_q <= 1'b1;
    end
  end

  assign proto_err_o = err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: rtl/cdc_handshake_rx.sv
// Multi-channel receive side of a req/ack CDC handshake; channels run fully in parallel.
// Latency: out_valid rises SYNC_STAGES+1 edges after req_in changes; ack_out moves on the accept edge.
// Backpressure: a channel with out_ready low keeps out_valid high and withholds its ack indefinitely.
// Ports: clk, reset (async active-low), req_in/data_in/ack_out toward the sender domain,
//        out_valid/out_data/out_ready local handshake, cap_pulse capture strobe, proto_err sticky flag.
// Optional macro CDC_RX_PROTOCOL_CHECK_EN enables the per-channel protocol checker.
module cdc_handshake_rx
  import cdc_rx_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FOUR_PHASE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic [NUM_CH-1:0]        ack_out,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH-1:0]        cap_pulse,
  output logic [NUM_CH-1:0]        proto_err
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("cdc_handshake_rx: SYNC_STAGES=%0d outside legal range", SYNC_STAGES);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cdc_rx_channel #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FOUR_PHASE  (FOUR_PHASE)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req_in[c]),
      .data_i      (data_in[c*DATA_W +: DATA_W]),
      .ack_o       (ack_out[c]),
      .out_valid_o (out_valid[c]),
      .out_data_o  (out_data[c*DATA_W +: DATA_W]),
      .out_ready_i (out_ready[c]),
      .cap_pulse_o (cap_pulse[c]),
      .proto_err_o (proto_err[c])
    );
  end

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench: a 2-channel 4-phase instance and a 1-channel 2-phase instance
// share clock and reset. Outputs are sampled 1 time unit after the rising edge.
module tb_cdc_handshake_rx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-phase, two channels
  logic [1:0]  a_req, a_rdy, a_ack, a_vld, a_cap, a_err;
  logic [15:0] a_data, a_odata;
  // 2-phase, one channel
  logic [0:0]  b_req, b_rdy, b_ack, b_vld, b_cap, b_err;
  logic [7:0]  b_data, b_odata;

  cdc_handshake_rx #(.NUM_CH(2), .DATA_W(8), .SYNC_STAGES(2), .FOUR_PHASE(1)) u_dut4 (
    .clk(clk), .reset(rst_n), .req_in(a_req), .data_in(a_data), .ack_out(a_ack),
    .out_valid(a_vld), .out_data(a_odata), .out_ready(a_rdy), .cap_pulse(a_cap),
    .proto_err(a_err)
  );

  cdc_handshake_rx #(.NUM_CH(1), .DATA_W(8), .SYNC_STAGES(2), .FOUR_PHASE(0)) u_dut2 (
    .clk(clk), .reset(rst_n), .req_in(b_req), .data_in(b_data), .ack_out(b_ack),
    .out_valid(b_vld), .out_data(b_odata), .out_ready(b_rdy), .cap_pulse(b_cap),
    .proto_err(b_err)
  );

`ifdef CDC_RX_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b1;
    a_req  = '0; a_rdy = '0; a_data = '0;
    b_req  = '0; b_rdy = '0; b_data = '0;
    #1 rst_n = 1'b0;
    #1;
    // Reset state
    chk("rst_a_ack",   a_ack,   2'b00);
    chk("rst_a_vld",   a_vld,   2'b00);
    chk("rst_a_odata", a_odata, 16'h0000);
    chk("rst_a_cap",   a_cap,   2'b00);
    chk("rst_a_err",   a_err,   2'b00);
    chk("rst_b_ack",   b_ack,   1'b0);
    chk("rst_b_vld",   b_vld,   1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 1: basic 4-phase transfer, ready held high
    a_rdy  = 2'b01;
    a_data = 16'h00A5;
    a_req  = 2'b01;
    tick(2);
    chk("t1_vld_early", a_vld, 2'b00);
    tick(1);
    chk("t1_vld",   a_vld,   2'b01);
    chk("t1_cap",   a_cap,   2'b01);
    chk("t1_data",  a_odata[7:0], 8'hA5);
    chk("t1_ack0",  a_ack,   2'b00);
    tick(1);
    chk("t1_ack1",  a_ack,   2'b01);
    chk("t1_vld0",  a_vld,   2'b00);
    chk("t1_cap0",  a_cap,   2'b00);
    a_req = 2'b00;
    tick(2);
    chk("t1_ack_hold", a_ack, 2'b01);
    tick(1);
    chk("t1_ack_fall", a_ack, 2'b00);
    chk("t1_data_kept", a_odata[7:0], 8'hA5);

    // 2: backpressure for 10 cycles
    a_rdy  = 2'b00;
    a_data = 16'h003C;
    a_req  = 2'b01;
    tick(3);
    chk("t2_vld",  a_vld, 2'b01);
    chk("t2_data", a_odata[7:0], 8'h3C);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t2_stall", {a_vld, a_ack}, {2'b01, 2'b00});
    end
    a_rdy = 2'b01;
    tick(1);
    chk("t2_ack", a_ack, 2'b01);
    chk("t2_vld0", a_vld, 2'b00);
    a_req = 2'b00;
    tick(3);
    chk("t2_ack_fall", a_ack, 2'b00);

    // 3: 2-phase, three toggles
    b_rdy  = 1'b1;
    b_data = 8'h01;
    b_req  = 1'b1;
    tick(3);
    chk("t3_vld1",  b_vld, 1'b1);
    chk("t3_cap1",  b_cap, 1'b1);
    chk("t3_data1", b_odata, 8'h01);
    chk("t3_pre1",  b_ack, 1'b0);
    tick(1);
    chk("t3_ack1",  b_ack, 1'b1);
    chk("t3_vld1b", b_vld, 1'b0);
    b_data = 8'h02;
    b_req  = 1'b0;
    tick(3);
    chk("t3_vld2",  b_vld, 1'b1);
    chk("t3_data2", b_odata, 8'h02);
    tick(1);
    chk("t3_ack2",  b_ack, 1'b0);
    b_data = 8'h03;
    b_req  = 1'b1;
    tick(3);
    chk("t3_data3", b_odata, 8'h03);
    tick(1);
    chk("t3_ack3",  b_ack, 1'b1);
    chk("t3_err",   b_err, 1'b0);

    // 4: two channels in parallel, channel 1 stalled
    a_rdy  = 2'b01;
    a_data = 16'h2211;
    a_req  = 2'b11;
    tick(3);
    chk("t4_vld",  a_vld, 2'b11);
    chk("t4_cap",  a_cap, 2'b11);
    chk("t4_data", a_odata, 16'h2211);
    tick(1);
    chk("t4_ack",  a_ack, 2'b01);
    chk("t4_vld1", a_vld, 2'b10);
    tick(5);
    chk("t4_ack_hold", a_ack, 2'b01);
    chk("t4_vld_hold", a_vld, 2'b10);
    a_rdy = 2'b11;
    tick(1);
    chk("t4_ack_both", a_ack, 2'b11);
    chk("t4_vld_none", a_vld, 2'b00);
    a_req = 2'b00;
    tick(3);
    chk("t4_ack_fall", a_ack, 2'b00);

    // 5: reset while holding 8'h5A
    a_rdy  = 2'b00;
    a_data = 16'h005A;
    a_req  = 2'b01;
    tick(3);
    chk("t5_vld",  a_vld, 2'b01);
    chk("t5_data", a_odata[7:0], 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld",  a_vld,   2'b00);
    chk("t5_rst_data", a_odata, 16'h0000);
    chk("t5_rst_ack",  a_ack,   2'b00);
    chk("t5_rst_cap",  a_cap,   2'b00);
    chk("t5_rst_back", b_ack,   1'b0);
    a_data = 16'h0077;
    #2 rst_n = 1'b1;
    tick(2);
    chk("t5_vld_early", a_vld, 2'b00);
    tick(1);
    chk("t5_vld2",  a_vld, 2'b01);
    chk("t5_cap2",  a_cap, 2'b01);
    chk("t5_data2", a_odata[7:0], 8'h77);
    // b_req is still 1 at release: seen as a fresh toggle event
    chk("t5_b_vld",  b_vld, 1'b1);
    chk("t5_b_data", b_odata, 8'h03);
    a_rdy = 2'b01;
    tick(1);
    chk("t5_ack", a_ack, 2'b01);
    a_req = 2'b00;
    tick(3);
    chk("t5_ack_fall", a_ack, 2'b00);

    // 6: request dropped while still holding
    a_rdy  = 2'b00;
    a_data = 16'h0099;
    a_req  = 2'b01;
    tick(3);
    chk("t6_vld", a_vld, 2'b01);
    a_req = 2'b00;
    tick(2);
    chk("t6_err_pre", a_err, 2'b00);
    tick(1);
    chk("t6_err", a_err, {1'b0, EXP_ERR});
    a_rdy = 2'b01;
    tick(1);
    chk("t6_ack", a_ack, 2'b01);
    tick(1);
    chk("t6_ack_fall", a_ack, 2'b00);
    tick(3);
    chk("t6_err_sticky", a_err, {1'b0, EXP_ERR});
    rst_n = 1'b0;
    #1;
    chk("t6_err_rst", a_err, 2'b00);
    #3 rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
Parametrised multi-channel receive side of a req/ack clock-domain-crossing handshake. Each channel does the following:
- synchronises an asynchronous request from the sender domain;
- captures the sender's stable data bus;
- presents the data on a valid/ready interface to the local domain;
- returns a registered, glitch-free acknowledge.
Supports 4-phase (level) and 2-phase (toggle) protocols and stalls the acknowledge until the local consumer accepts the data.

Parameters:
- NUM_CH, 1, number of independent channels.
- DATA_W, 8, data width per channel.
- SYNC_STAGES, 2, request synchroniser depth (legal 2..4).
- FOUR_PHASE, 1, 1 = 4-phase level protocol, 0 = 2-phase toggle protocol.

Ports:
- clk  input  1  receiver-domain clock.
- reset  input  1  asynchronous, active-low reset.
- req_in  input  NUM_CH  per-channel request from the sender domain (asynchronous).
- data_in  input  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]; the sender holds it stable from req assertion/toggle until ack.
- ack_out  output  NUM_CH  per-channel acknowledge to the sender, driven directly from a flop.
- out_valid  output  NUM_CH  captured data available.
- out_data  output  NUM_CH*DATA_W  captured data, channel-sliced as data_in.
- out_ready  input  NUM_CH  local consumer accepts.
- cap_pulse  output  NUM_CH  one-cycle strobe on the capture edge.
- proto_err  output  NUM_CH  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - synchroniser flops, ack_out, out_valid, cap_pulse and proto_err all go to 0.
  - out_data goes to 0; state goes to IDLE; req_seen goes to 0.
  - Mid-operation reset abandons any transfer; the sender domain is reset together with this block.
- Synchroniser: SYNC_STAGES flops per channel; req_sync is the last stage. No combinational logic sits before the first stage.
- Per-channel FSM states: IDLE, HOLD, ACK.
- 4-phase (FOUR_PHASE=1):
  - IDLE with req_sync=1: out_data <= data_in, out_valid <= 1, cap_pulse <= 1, go to HOLD.
  - HOLD with out_ready=1: out_valid <= 0, go to ACK. ack_out rises on the same edge, because ack_out is registered from next-state (look-ahead).
  - ACK with req_sync=0: go to IDLE, and ack_out falls on the same edge.
  - HOLD with out_ready=0: hold indefinitely; ack_out stays 0.
- 2-phase (FOUR_PHASE=0):
  - Event = req_sync != req_seen.
  - IDLE with an event: capture as above, req_seen <= req_sync, go to HOLD.
  - HOLD with out_ready=1: out_valid <= 0, ack_out <= req_seen (toggle), go to IDLE. The ACK state is unused.
- Latency:
  - out_valid rises at edge SYNC_STAGES+1 after the first edge sampling req_in changed.
  - ack_out changes at the edge where out_valid & out_ready is sampled.
- cap_pulse is high for exactly one cycle, coincident with the first out_valid cycle.
- out_data holds its value until the next capture.
- Channels are fully independent. Simultaneous events on different channels are handled in parallel, with no arbitration.
- A request present at reset release is treated as a new request once synchronised.

Optional Feature:
Macro: CDC_RX_PROTOCOL_CHECK_EN
- Defined:
  - proto_err[c] sets and stays set until reset.
  - 4-phase: set when req_sync falls while in HOLD.
  - 2-phase: set when a second event arrives while in HOLD.
  - FSM behaviour is unchanged by an error.
- Undefined: proto_err is tied to 0 and no checker logic is generated.

Decomposition:
- Package cdc_rx_pkg: state encoding constants ST_IDLE=2'd0, ST_HOLD=2'd1, ST_ACK=2'd2, and the legal SYNC_STAGES bounds.
- Sub-module cdc_rx_channel: one channel (synchroniser, FSM, capture register, checker).
- The top instantiates NUM_CH copies in a generate loop and does the slicing.

Test Plan:
1. 4-phase, NUM_CH=1, SYNC_STAGES=2, out_ready held 1; req_in 0->1 with data_in=8'hA5.
   - out_valid and cap_pulse high 3 edges later; out_data=8'hA5.
   - ack_out=1 on the next edge.
   - req_in->0 gives ack_out=0 three edges later.
2. 4-phase backpressure: out_ready=0 for 10 cycles after capture.
   - out_valid stays 1 and ack_out stays 0 throughout.
   - Assert out_ready: ack_out=1 at that edge; out_valid=0.
3. 2-phase, FOUR_PHASE=0: toggle req_in three times with data 8'h01, 8'h02, 8'h03, each after the ack.
   - Three captures in order; ack_out toggles 1, 0, 1.
4. NUM_CH=2: simultaneous requests with data 8'h11 and 8'h22, out_ready[0]=1 and out_ready[1]=0.
   - ack_out=2'b01; channel 1 is unaffected until its ready is asserted.
5. Reset asserted while in HOLD with out_data=8'h5A.
   - All outputs 0 immediately, without a clock edge.
   - After release with req_in=1, a fresh capture completes normally.
6. With CDC_RX_PROTOCOL_CHECK_EN defined, 4-phase: drop req_in while out_ready=0.
   - proto_err=1, sticky until reset.
   - Without the macro, proto_err stays 0.
